// File: rtl/sdc_spi_engine_pkg.sv
// sdc_spi_engine_pkg: shared definitions for the SD card SPI shift engine.
//   - FSM state encodings (idle / sclk low phase / sclk high phase)
//   - transfer lengths for byte and word mode
//   - last_bit(): index of the final bit for the latched transfer width
// Build option: SDC_SPI_WORD_EN (see sdc_spi_engine.sv).
package sdc_spi_engine_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLo   = 2'd1;
  localparam logic [1:0] StHi   = 2'd2;

  localparam int unsigned ByteBits = 8;
  localparam int unsigned WordBits = 32;

  // Bit counter is sized for the longest transfer.
  localparam int unsigned BitCntW = $clog2(WordBits);

  function automatic logic [BitCntW-1:0] last_bit(input logic word);
    return word ? BitCntW'(WordBits - 1) : BitCntW'(ByteBits - 1);
  endfunction

endpackage

// File: rtl/sdc_spi_engine_tick.sv
// sdc_spi_engine_tick: sclk half-period tick generator.
// The divider restarts on load (accepted start), latches the rate select and, while run is high,
// pulses tick on the last cycle of each half-period, then wraps to 0 for the next phase.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous reset, active high
//   load  in  accepted start: clear divider, latch fast
//   fast  in  rate select, sampled only on load
//   run   in  engine busy; divider counts only while high
//   tick  out one-cycle pulse at end of a half-period
module sdc_spi_engine_tick #(
  parameter int unsigned HALF_SLOW = 32,
  parameter int unsigned HALF_FAST = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic fast,
  input  logic run,
  output logic tick
);

  localparam int unsigned CntW = $clog2(HALF_SLOW + 1);

  localparam logic [CntW-1:0] TermSlow = CntW'(HALF_SLOW - 1);
  localparam logic [CntW-1:0] TermFast = CntW'(HALF_FAST - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            fast_d, fast_q;
  logic [CntW-1:0] term;

  assign term = fast_q ? TermFast : TermSlow;
  assign tick = run & (cnt_q == term);

  always_comb begin
    cnt_d  = cnt_q;
    fast_d = fast_q;
    if (load) begin
      cnt_d  = '0;
      fast_d = fast;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      fast_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fast_q <= fast_d;
    end
  end

endmodule

// File: rtl/sdc_spi_engine.sv
// sdc_spi_engine: SPI mode 0 shift engine below the SD card register interface.
// MSB first; miso sampled on sclk rise, mosi changes on sclk fall. Busy for 2*HALF*N cycles.
// Build option: SDC_SPI_WORD_EN -- when defined, fast=1 also selects 32-bit transfers; when
// undefined every transfer is 8 bits and fast only selects the rate.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active high
//   fast    in   rate (and word width) select, sampled on accepted start
//   start   in   one-cycle transfer request, ignored while busy
//   dataTx  in   transmit word, sampled on accepted start (byte mode uses [7:0])
//   dataRx  out  received word, held until the next completed transfer
//   rdy     out  1 = idle, 0 = busy
//   sclk    out  SPI clock, idles low
//   mosi    out  SPI data out, idles high
//   miso    in   SPI data in
module sdc_spi_engine
  import sdc_spi_engine_pkg::*;
#(
  parameter int unsigned HALF_SLOW = 32,
  parameter int unsigned HALF_FAST = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fast,
  input  logic        start,
  input  logic [31:0] dataTx,
  output logic [31:0] dataRx,
  output logic        rdy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  logic [1:0]         state_d, state_q;
  logic [31:0]        tx_d, tx_q;
  logic [31:0]        rx_d, rx_q;
  logic [31:0]        data_rx_d, data_rx_q;
  logic [BitCntW-1:0] bitcnt_d, bitcnt_q;
  logic               word_d, word_q;
  logic               sclk_d, sclk_q;
  logic               mosi_d, mosi_q;
  logic               accept;
  logic               tick;
  logic               word_sel;

  assign accept = (state_q == StIdle) & start;

`ifdef SDC_SPI_WORD_EN
  assign word_sel = fast;
`else
  assign word_sel = 1'b0;
`endif

  sdc_spi_engine_tick #(
    .HALF_SLOW(HALF_SLOW),
    .HALF_FAST(HALF_FAST)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .fast(fast),
    .run (state_q != StIdle),
    .tick(tick)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rx_d = data_rx_q;
    bitcnt_d  = bitcnt_q;
    word_d    = word_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          word_d   = word_sel;
          // Byte mode left-aligns the byte so the MSB always leaves from bit 31.
          tx_d     = word_sel ? dataTx : {dataTx[7:0], 24'h0};
          rx_d     = '0;
          bitcnt_d = '0;
          sclk_d   = 1'b0;
          mosi_d   = word_sel ? dataTx[31] : dataTx[7];
          state_d  = StLo;
        end
      end
      StLo: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[30:0], miso};
          state_d = StHi;
        end
      end
      StHi: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (bitcnt_q == last_bit(word_q)) begin
            mosi_d    = 1'b1;
            data_rx_d = word_q ? rx_q : {24'h0, rx_q[7:0]};
            state_d   = StIdle;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
            tx_d     = {tx_q[30:0], 1'b0};
            mosi_d   = tx_q[30];
            state_d  = StLo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
      bitcnt_q  <= '0;
      word_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
      bitcnt_q  <= bitcnt_d;
      word_q    <= word_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end

  assign rdy    = (state_q == StIdle);
  assign sclk   = sclk_q;
  assign mosi   = mosi_q;
  assign dataRx = data_rx_q;

endmodule

// File: tb/tb_sdc_spi_engine.sv
// Directed bench for sdc_spi_engine with default HALF_SLOW=32, HALF_FAST=2.
module tb_sdc_spi_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        fast;
  logic        start;
  logic [31:0] dataTx;
  logic [31:0] dataRx;
  logic        rdy;
  logic        sclk;
  logic        mosi;
  logic        miso;

  logic        loop_en;
  logic [31:0] model_q;

  int tests = 0;
  int fails = 0;

  // Card model: loopback of mosi, or a shift register presenting its MSB.
  assign miso = loop_en ? mosi : model_q[31];

  always #5 clk = ~clk;

  sdc_spi_engine dut (
    .clk   (clk),
    .rst   (rst),
    .fast  (fast),
    .start (start),
    .dataTx(dataTx),
    .dataRx(dataRx),
    .rdy   (rdy),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso)
  );

  // Starts a transfer on the next edge and observes it at every falling clk edge until rdy.
  // busy counts sampled cycles with rdy=0; mosi bits are captured at each sclk rise.
  // inject_at>0 drives start with dataTx=FF for one cycle at that busy count.
  task automatic do_xfer(input logic f, input logic [31:0] d, input int inject_at,
                         output int busy, output int rises, output logic [31:0] mosi_seq,
                         output int hi_run);
    logic prev_sclk;
    int   run_len;
    busy = 0; rises = 0; mosi_seq = '0; hi_run = 0; run_len = 0; prev_sclk = 1'b0;
    fast = f; dataTx = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; fast = ~f; dataTx = 32'hFFFF_FFFF;
    while (rdy == 1'b0 && busy < 5000) begin
      busy++;
      if (busy == inject_at) begin
        start = 1'b1; dataTx = 32'h0000_00FF;
      end else begin
        start = 1'b0;
      end
      if (sclk && !prev_sclk) begin
        rises++;
        mosi_seq = {mosi_seq[30:0], mosi};
      end
      if (!sclk && prev_sclk) begin
        hi_run  = run_len;
        model_q = model_q << 1;
      end
      run_len   = sclk ? run_len + 1 : 0;
      prev_sclk = sclk;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; fast = 1'b0; dataTx = '0; loop_en = 1'b1; model_q = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b want 1", rdy); end
    tests++; if (sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    tests++; if (mosi !== 1'b1) begin fails++; $display("FAIL reset_mosi: got %b want 1", mosi); end
    tests++;
    if (dataRx !== 32'h0) begin fails++; $display("FAIL reset_rx: got %h want 0", dataRx); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_slow_byte;
    int busy, rises, hi; logic [31:0] seq;
    loop_en = 1'b1;
    do_xfer(1'b0, 32'h0000_00A5, 0, busy, rises, seq, hi);
    tests++; if (busy != 512) begin fails++; $display("FAIL slow_busy: got %0d want 512", busy); end
    tests++; if (rises != 8) begin fails++; $display("FAIL slow_rises: got %0d want 8", rises); end
    tests++;
    if (seq !== 32'hA5) begin fails++; $display("FAIL slow_mosi: got %h want a5", seq); end
    tests++;
    if (dataRx !== 32'hA5) begin fails++; $display("FAIL slow_rx: got %h want a5", dataRx); end
    tests++; if (hi != 32) begin fails++; $display("FAIL slow_half: got %0d want 32", hi); end
    tests++; if (mosi !== 1'b1) begin fails++; $display("FAIL slow_idle_mosi: got %b want 1", mosi); end
  endtask

`ifdef SDC_SPI_WORD_EN
  task automatic test_fast_word;
    int busy, rises, hi; logic [31:0] seq;
    loop_en = 1'b0; model_q = 32'h1234_5678;
    do_xfer(1'b1, 32'hDEAD_BEEF, 0, busy, rises, seq, hi);
    tests++; if (busy != 128) begin fails++; $display("FAIL word_busy: got %0d want 128", busy); end
    tests++; if (rises != 32) begin fails++; $display("FAIL word_rises: got %0d want 32", rises); end
    tests++;
    if (seq !== 32'hDEAD_BEEF) begin fails++; $display("FAIL word_mosi: got %h want deadbeef", seq); end
    tests++;
    if (dataRx !== 32'h1234_5678) begin fails++; $display("FAIL word_rx: got %h want 12345678", dataRx); end
    tests++; if (hi != 2) begin fails++; $display("FAIL word_half: got %0d want 2", hi); end
  endtask
`else
  task automatic test_fast_byte;
    int busy, rises, hi; logic [31:0] seq;
    loop_en = 1'b0; model_q = 32'h5A00_0000;
    do_xfer(1'b1, 32'hCAFE_0081, 0, busy, rises, seq, hi);
    tests++; if (busy != 32) begin fails++; $display("FAIL fastb_busy: got %0d want 32", busy); end
    tests++; if (rises != 8) begin fails++; $display("FAIL fastb_rises: got %0d want 8", rises); end
    tests++;
    if (seq !== 32'h81) begin fails++; $display("FAIL fastb_mosi: got %h want 81", seq); end
    tests++;
    if (dataRx !== 32'h5A) begin fails++; $display("FAIL fastb_rx: got %h want 5a", dataRx); end
    tests++; if (hi != 2) begin fails++; $display("FAIL fastb_half: got %0d want 2", hi); end
  endtask
`endif

  task automatic test_busy_start;
    int busy, rises, hi; logic [31:0] seq;
    loop_en = 1'b1;
    do_xfer(1'b0, 32'h0000_003C, 100, busy, rises, seq, hi);
    tests++; if (busy != 512) begin fails++; $display("FAIL busy_busy: got %0d want 512", busy); end
    tests++; if (rises != 8) begin fails++; $display("FAIL busy_rises: got %0d want 8", rises); end
    tests++;
    if (seq !== 32'h3C) begin fails++; $display("FAIL busy_mosi: got %h want 3c", seq); end
    tests++;
    if (dataRx !== 32'h3C) begin fails++; $display("FAIL busy_rx: got %h want 3c", dataRx); end
  endtask

  // start held across the completion edge must not launch a new transfer.
  task automatic test_completion_start;
    int busy, rises, hi; logic [31:0] seq;
    loop_en = 1'b1;
    do_xfer(1'b0, 32'h0000_0096, 512, busy, rises, seq, hi);
    tests++; if (busy != 512) begin fails++; $display("FAIL cmpl_busy: got %0d want 512", busy); end
    repeat (3) @(negedge clk);
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL cmpl_rdy: got %b want 1", rdy); end
    tests++; if (sclk !== 1'b0) begin fails++; $display("FAIL cmpl_sclk: got %b want 0", sclk); end
    tests++;
    if (dataRx !== 32'h96) begin fails++; $display("FAIL cmpl_rx: got %h want 96", dataRx); end
  endtask

  task automatic test_reset_mid;
    loop_en = 1'b1;
    fast = 1'b1; dataTx = 32'h0000_00F0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL rstm_busy: got %b want 0", rdy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL rstm_rdy: got %b want 1", rdy); end
    tests++; if (sclk !== 1'b0) begin fails++; $display("FAIL rstm_sclk: got %b want 0", sclk); end
    tests++; if (mosi !== 1'b1) begin fails++; $display("FAIL rstm_mosi: got %b want 1", mosi); end
    tests++;
    if (dataRx !== 32'h0) begin fails++; $display("FAIL rstm_rx: got %h want 0", dataRx); end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL rstm_stay: got %b want 1", rdy); end
    tests++;
    if (dataRx !== 32'h0) begin fails++; $display("FAIL rstm_rx_hold: got %h want 0", dataRx); end
  endtask

  task automatic test_back_to_back;
    int busy, rises, hi; logic [31:0] seq;
    loop_en = 1'b1;
    do_xfer(1'b0, 32'h0000_00C3, 0, busy, rises, seq, hi);
    tests++; if (busy != 512) begin fails++; $display("FAIL b2b1_busy: got %0d want 512", busy); end
    tests++;
    if (dataRx !== 32'hC3) begin fails++; $display("FAIL b2b1_rx: got %h want c3", dataRx); end
    // Issue the next start on the very first rdy=1 cycle.
    do_xfer(1'b0, 32'h1234_565A, 0, busy, rises, seq, hi);
    tests++; if (busy != 512) begin fails++; $display("FAIL b2b2_busy: got %0d want 512", busy); end
    tests++;
    if (seq !== 32'h5A) begin fails++; $display("FAIL b2b2_mosi: got %h want 5a", seq); end
    tests++;
    if (dataRx !== 32'h5A) begin fails++; $display("FAIL b2b2_rx: got %h want 5a", dataRx); end
  endtask

  initial begin
    test_reset();
    test_slow_byte();
`ifdef SDC_SPI_WORD_EN
    test_fast_word();
`else
    test_fast_byte();
`endif
    test_busy_start();
    test_completion_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
